sequence_draw_reader: RTL and testbench
=======================================

Name: sequence_draw_reader

Overview:
- Read-side counterpart of the sort-sequence datapath.
- Walks the elementSeq RAM (32x5) that the datapath fills, one entry per index, and turns each entry into a vertical bar drawn pixel by pixel into the VGA plotter.
- Bar width comes from the datapath's block_width. A go/done handshake lets the top-level FSM start a redraw after every sort step.

Parameters:
- SCREEN_W, 600, drawable width in pixels; any x >= SCREEN_W is never plotted.
- Y_BASE, 479, y coordinate of the bottom pixel row of every bar.
- BAR_UNIT, 12, pixels of bar height per unit of element value (height = (v+1)*BAR_UNIT).
- RAM_LATENCY, 2, cycles from elementSeq_addr change to valid elementSeq_out.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and the reset values below
- go_draw  in  1  level request to start a full redraw
- draw_done  out  1  high in DONE until go_draw falls
- elementSeq_addr  out  5  read address into elementSeq RAM
- elementSeq_out  in  5  element value at elementSeq_addr, valid RAM_LATENCY cycles after the address changes
- numElements  in  5  number of bars to draw (indices 0..numElements-1)
- block_width  in  10  bar width in pixels
- highlight_idx  in  5  index drawn in highlight colour
- x  out  10  pixel x
- y  out  9  pixel y
- colour  out  3  pixel colour {R,G,B}
- plot  out  1  high for exactly the cycles in which x/y/colour are a pixel to write

Behaviour:
- Reset values: state=IDLE; draw_done=0, plot=0, x=0, y=0, colour=0, elementSeq_addr=0; internal counters 0.
- Reset is asynchronous and takes effect mid-draw. The partially drawn frame is abandoned, and there are no plot pulses until the next go_draw.
- States:
  - IDLE: wait for go_draw=1. In that cycle latch numElements, block_width and highlight_idx into n_l, w_l and h_l; set idx=0 and elementSeq_addr=0. If n_l==0 or w_l==0, go to DONE; else go to FETCH.
  - FETCH: wait RAM_LATENCY cycles, then latch v=elementSeq_out; set dx=0, dy=0, x_base=idx*w_l (10 bits); go to DRAW.
  - DRAW: one pixel per cycle, with registered outputs.
    - Drive x=x_base+dx, y=Y_BASE-dy.
    - plot=1 only if x_base+dx < SCREEN_W, computed at 11 bits so no wrap.
    - Scan order: dy counts 0..(v+1)*BAR_UNIT-1 (bottom to top) within a column, then dx increments.
    - After pixel (w_l-1, top), go to NEXT.
  - NEXT: plot=0. If idx==n_l-1, go to DONE. Else idx++, elementSeq_addr=idx, go to FETCH.
  - DONE: draw_done=1, plot=0. When go_draw=0, go to IDLE with draw_done=0 on the following edge.
- Colour rules:
  - Column dx==w_l-1 with w_l>=2 is black (3'b000), the gap between bars.
  - Otherwise the column is red (3'b100) if idx==h_l, else white (3'b111).
  - w_l==1: no gap column.
- Bar height ≤ 32*12 = 384 ≤ Y_BASE, so y never underflows for the default parameters.
- Arithmetic widths:
  - dx: 10 bits.
  - dy: 9 bits.
  - x_base: product truncated to 10 bits. Any overflow beyond SCREEN_W is clipped by the plot gating.
- Pixels per bar = w_l*(v+1)*BAR_UNIT. Plot pulses are contiguous within a bar. There is a gap of 1 NEXT cycle plus RAM_LATENCY+1 FETCH cycles between bars.
- Inputs change mid-draw: numElements, block_width and highlight_idx are ignored; latched values are used.
- go_draw falling mid-draw: ignored, and the draw completes. DONE is then left on the next edge.
- go_draw held high after DONE: stay in DONE. A new redraw requires go_draw to fall and rise again.
- elementSeq RAM is read-only here; this block has no write enable.

Test Plan:
1. reset pulse mid-DRAW (go_draw=1, numElements=4) -> plot=0 and draw_done=0 asynchronously. No plot pulses until go_draw is toggled low and then high.
2. numElements=2, block_width=3, RAM[0]=0, RAM[1]=1, highlight_idx=31 -> exactly 36+72=108 plot pulses.
   - First pixel: x=0, y=479, colour=7.
   - Bar 1 starts at x=3.
   - Columns x=2 and x=5 are black.
   - draw_done=1 afterwards.
3. Same setup with highlight_idx=1 -> columns x=3,4 are colour=4 and x=5 is black; bar 0 colours are unchanged.
4. numElements=0 or block_width=0 with go_draw=1 -> draw_done=1 within 2 cycles and zero plot pulses.
5. numElements=31, block_width=20, all RAM=0 -> bars at x_base ≥ 600 (idx 30) produce no plot pulses; total = 30*20*12 = 7200 pulses.
6. Change numElements and block_width and drop go_draw mid-draw -> drawing completes with the latched values, and DONE→IDLE occurs one cycle after DONE is entered.

Source files
------------

// File: rtl/sequence_draw_reader.sv
// Read side of the sort-sequence datapath: walks elementSeq RAM and plots one
// vertical bar per element into the VGA plotter, one pixel per cycle.
`timescale 1ns/1ps
module sequence_draw_reader #(
    parameter int unsigned SCREEN_W    = 600,
    parameter int unsigned Y_BASE      = 479,
    parameter int unsigned BAR_UNIT    = 12,
    parameter int unsigned RAM_LATENCY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go_draw,
    output logic       draw_done,
    output logic [4:0] elementSeq_addr,
    input  logic [4:0] elementSeq_out,
    input  logic [4:0] numElements,
    input  logic [9:0] block_width,
    input  logic [4:0] highlight_idx,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic [2:0] colour,
    output logic       plot
);

    // state | meaning
    // IDLE  | wait for a fresh go_draw, latch geometry
    // FETCH | address presented, wait out RAM latency, latch element value
    // DRAW  | emit one pixel per cycle, column by column, bottom to top
    // NEXT  | advance to the next element or finish
    // DONE  | hold draw_done until go_draw is released
    typedef enum logic [2:0] {IDLE, FETCH, DRAW, NEXT, DONE} state_t;

    state_t state, state_nxt;

    logic [4:0]  n_l, n_nxt, h_l, h_nxt, idx, idx_nxt, addr_nxt, v_l, v_nxt;
    logic [9:0]  w_l, w_nxt, dx, dx_nxt, x_base, xb_nxt, x_nxt;
    logic [8:0]  dy, dy_nxt, y_nxt, bar_top;
    logic [3:0]  wait_cnt, wait_nxt;
    logic [2:0]  colour_nxt;
    logic        plot_nxt, draw_done_nxt, armed, armed_nxt;
    logic [10:0] x_sum;

    assign bar_top = (9'(v_l) + 9'd1) * 9'(BAR_UNIT) - 9'd1;
    assign x_sum   = 11'(x_base) + 11'(dx);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            n_l             <= '0;
            w_l             <= '0;
            h_l             <= '0;
            idx             <= '0;
            elementSeq_addr <= '0;
            wait_cnt        <= '0;
            v_l             <= '0;
            dx              <= '0;
            dy              <= '0;
            x_base          <= '0;
            x               <= '0;
            y               <= '0;
            colour          <= '0;
            plot            <= 1'b0;
            draw_done       <= 1'b0;
            armed           <= 1'b0;
        end else begin
            state           <= state_nxt;
            n_l             <= n_nxt;
            w_l             <= w_nxt;
            h_l             <= h_nxt;
            idx             <= idx_nxt;
            elementSeq_addr <= addr_nxt;
            wait_cnt        <= wait_nxt;
            v_l             <= v_nxt;
            dx              <= dx_nxt;
            dy              <= dy_nxt;
            x_base          <= xb_nxt;
            x               <= x_nxt;
            y               <= y_nxt;
            colour          <= colour_nxt;
            plot            <= plot_nxt;
            draw_done       <= draw_done_nxt;
            armed           <= armed_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        n_nxt      = n_l;
        w_nxt      = w_l;
        h_nxt      = h_l;
        idx_nxt    = idx;
        addr_nxt   = elementSeq_addr;
        wait_nxt   = wait_cnt;
        v_nxt      = v_l;
        dx_nxt     = dx;
        dy_nxt     = dy;
        xb_nxt     = x_base;
        x_nxt      = x;
        y_nxt      = y;
        colour_nxt = colour;
        plot_nxt   = 1'b0;
        // A redraw needs go_draw to have been seen low since the last start or reset.
        armed_nxt  = armed | ~go_draw;

        case (state)
            IDLE: begin
                if (go_draw && armed) begin
                    n_nxt     = numElements;
                    w_nxt     = block_width;
                    h_nxt     = highlight_idx;
                    idx_nxt   = '0;
                    addr_nxt  = '0;
                    wait_nxt  = 4'(RAM_LATENCY);
                    armed_nxt = 1'b0;
                    state_nxt = (numElements == 5'd0 || block_width == 10'd0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (wait_cnt == 4'd0) begin
                    v_nxt     = elementSeq_out;
                    dx_nxt    = '0;
                    dy_nxt    = '0;
                    xb_nxt    = 10'(idx) * w_l;
                    state_nxt = DRAW;
                end else begin
                    wait_nxt = wait_cnt - 4'd1;
                end
            end
            DRAW: begin
                x_nxt    = x_sum[9:0];
                y_nxt    = 9'(Y_BASE) - dy;
                plot_nxt = (x_sum < 11'(SCREEN_W));
                if (dx == w_l - 10'd1 && w_l > 10'd1)
                    colour_nxt = 3'b000;
                else if (idx == h_l)
                    colour_nxt = 3'b100;
                else
                    colour_nxt = 3'b111;
                if (dy == bar_top) begin
                    dy_nxt = '0;
                    if (dx == w_l - 10'd1)
                        state_nxt = NEXT;
                    else
                        dx_nxt = dx + 10'd1;
                end else begin
                    dy_nxt = dy + 9'd1;
                end
            end
            NEXT: begin
                if (idx == n_l - 5'd1) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = idx + 5'd1;
                    addr_nxt  = idx + 5'd1;
                    wait_nxt  = 4'(RAM_LATENCY);
                    state_nxt = FETCH;
                end
            end
            DONE: begin
                if (!go_draw)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        draw_done_nxt = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_sequence_draw_reader.sv
// Bench for sequence_draw_reader: table of redraw vectors with hand-computed
// pixel statistics, plus sequences for reset mid-draw and mid-draw input changes.
`timescale 1ns/1ps
module tb_sequence_draw_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       go_draw;
    logic       draw_done;
    logic [4:0] elementSeq_addr;
    logic [4:0] elementSeq_out;
    logic [4:0] numElements;
    logic [9:0] block_width;
    logic [4:0] highlight_idx;
    logic [9:0] x;
    logic [8:0] y;
    logic [2:0] colour;
    logic       plot;

    sequence_draw_reader dut (
        .clk(clk), .reset(reset), .go_draw(go_draw), .draw_done(draw_done),
        .elementSeq_addr(elementSeq_addr), .elementSeq_out(elementSeq_out),
        .numElements(numElements), .block_width(block_width),
        .highlight_idx(highlight_idx), .x(x), .y(y), .colour(colour), .plot(plot)
    );

    always #5 clk = ~clk;

    // two-cycle read latency RAM model
    logic [4:0] ram [32];
    logic [4:0] ram_d1;
    always @(posedge clk) begin
        ram_d1         <= ram[elementSeq_addr];
        elementSeq_out <= ram_d1;
    end

    // pixel statistics collected on the falling edge
    int         pulses, col_mixed, max_x;
    int         cnt_at [1024];
    logic [2:0] col_at [1024];
    bit         have_first, clr;
    logic [9:0] fx;
    logic [8:0] fy;
    logic [2:0] fc;

    always @(negedge clk) begin
        if (clr) begin
            pulses     <= 0;
            col_mixed  <= 0;
            max_x      <= 0;
            have_first <= 1'b0;
            for (int i = 0; i < 1024; i++) begin
                cnt_at[i] <= 0;
                col_at[i] <= 3'd0;
            end
        end else if (plot) begin
            if (!have_first) begin
                have_first <= 1'b1;
                fx <= x;
                fy <= y;
                fc <= colour;
            end
            if (cnt_at[x] > 0 && col_at[x] != colour)
                col_mixed <= col_mixed + 1;
            col_at[x] <= colour;
            cnt_at[x] <= cnt_at[x] + 1;
            pulses    <= pulses + 1;
            if (int'(x) > max_x)
                max_x <= int'(x);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        int n; int w; int h; int mode;
        int exp_pulses; int exp_max; int exp_fc;
        int pa_x; int pa_c; int pa_n;
        int pb_x; int pb_c; int pb_n;
    } vec_t;

    vec_t vecs [7];

    task automatic fill_ram(input int mode);
        for (int i = 0; i < 32; i++)
            ram[i] = (mode == 1) ? 5'(i % 2) : 5'd0;
    endtask

    task automatic clear_stats();
        @(posedge clk); #1 clr = 1'b1;
        @(negedge clk); #1 clr = 1'b0;
    endtask

    task automatic wait_done(input string name, output int cyc);
        cyc = 0;
        while (!draw_done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, "_done_reached"}, int'(draw_done), 1);
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int    cyc;
        string nm;
        nm = $sformatf("vec%0d", k);
        fill_ram(v.mode);
        clear_stats();
        @(posedge clk); #1;
        numElements   = 5'(v.n);
        block_width   = 10'(v.w);
        highlight_idx = 5'(v.h);
        go_draw       = 1'b1;
        wait_done(nm, cyc);
        if (v.exp_pulses == 0)
            chk({nm, "_quick_done"}, int'(cyc <= 2), 1);
        repeat (3) @(negedge clk);
        chk({nm, "_done_held"}, int'(draw_done), 1);
        chk({nm, "_pulses"}, pulses, v.exp_pulses);
        chk({nm, "_max_x"}, max_x, v.exp_max);
        chk({nm, "_col_uniform"}, col_mixed, 0);
        if (v.exp_pulses > 0) begin
            chk({nm, "_first_x"}, int'(fx), 0);
            chk({nm, "_first_y"}, int'(fy), 479);
            chk({nm, "_first_c"}, int'(fc), v.exp_fc);
        end
        chk({nm, "_cnt_a"}, cnt_at[v.pa_x], v.pa_n);
        if (v.pa_n > 0) chk({nm, "_col_a"}, int'(col_at[v.pa_x]), v.pa_c);
        chk({nm, "_cnt_b"}, cnt_at[v.pb_x], v.pb_n);
        if (v.pb_n > 0) chk({nm, "_col_b"}, int'(col_at[v.pb_x]), v.pb_c);
        @(posedge clk); #1 go_draw = 1'b0;
        @(negedge clk);
        chk({nm, "_done_until_edge"}, int'(draw_done), 1);
        @(negedge clk);
        chk({nm, "_done_released"}, int'(draw_done), 0);
    endtask

    initial begin
        int cyc;
        //            n   w   h  mode pulses max fc   pa_x c  n    pb_x c  n
        vecs[0] = '{  2,  3, 31, 1,   108,   5,  7,   2,   0, 12,  5,   0, 24};
        vecs[1] = '{  2,  3,  1, 1,   108,   5,  7,   3,   4, 24,  0,   7, 12};
        vecs[2] = '{  0,  3,  0, 1,     0,   0,  0,   0,   0,  0,  1,   0,  0};
        vecs[3] = '{  3,  0,  0, 1,     0,   0,  0,   0,   0,  0,  1,   0,  0};
        vecs[4] = '{ 31, 20,  0, 0,  7200, 599,  4,   0,   4, 12, 599,  0, 12};
        vecs[5] = '{  1,  1,  0, 1,    12,   0,  4,   0,   4, 12,  1,   0,  0};
        vecs[6] = '{  3,  2,  2, 1,    96,   5,  7,   4,   4, 12,  3,   0, 24};

        reset = 1'b1; go_draw = 1'b0; clr = 1'b1;
        numElements = '0; block_width = '0; highlight_idx = '0;
        fill_ram(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_plot", int'(plot), 0);
        chk("rst_done", int'(draw_done), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_colour", int'(colour), 0);
        chk("rst_addr", int'(elementSeq_addr), 0);
        #1 reset = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);

        for (int k = 0; k < 7; k++)
            run_vec(k, vecs[k]);

        // reset mid-draw, then go_draw held high must not restart
        fill_ram(1);
        clear_stats();
        @(posedge clk); #1;
        numElements = 5'd4; block_width = 10'd3; highlight_idx = 5'd31; go_draw = 1'b1;
        repeat (30) @(negedge clk);
        chk("pre_reset_plot", int'(plot), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_plot", int'(plot), 0);
        chk("async_rst_done", int'(draw_done), 0);
        @(posedge clk); #1 reset = 1'b0;
        clear_stats();
        repeat (40) @(negedge clk);
        chk("post_reset_no_plot", pulses, 0);
        @(posedge clk); #1 go_draw = 1'b0;
        repeat (2) @(posedge clk);
        #1 go_draw = 1'b1;
        wait_done("rearm", cyc);
        chk("rearm_pulses", pulses, 216);
        @(posedge clk); #1 go_draw = 1'b0;
        repeat (3) @(posedge clk);

        // inputs change and go_draw drops mid-draw
        clear_stats();
        @(posedge clk); #1;
        numElements = 5'd2; block_width = 10'd3; highlight_idx = 5'd31; go_draw = 1'b1;
        repeat (10) @(posedge clk);
        #1 numElements = 5'd5; block_width = 10'd7; highlight_idx = 5'd0; go_draw = 1'b0;
        wait_done("latched", cyc);
        chk("latched_pulses", pulses, 108);
        chk("latched_max_x", max_x, 5);
        chk("latched_col0", int'(col_at[0]), 7);
        chk("latched_cnt3", cnt_at[3], 24);
        @(negedge clk);
        chk("latched_done_one_cycle", int'(draw_done), 0);
        repeat (5) @(negedge clk);
        chk("latched_no_restart", pulses, 108);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
